// File: rtl/wb_pipe_skid_if.sv
// Writeback-stage bus bundle: upstream beat, downstream head beat, flush and occupancy.
interface wb_pipe_skid_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5
);
    logic              flush_i;
    logic              in_valid_i;
    logic              in_ready_o;
    logic              RegWrite_i;
    logic              MemtoReg_i;
    logic [DATA_W-1:0] dataMem_data_i;
    logic [DATA_W-1:0] ALU_result_i;
    logic [ADDR_W-1:0] RDaddr_i;
    logic              out_valid_o;
    logic              out_ready_i;
    logic              RegWrite_o;
    logic              MemtoReg_o;
    logic [DATA_W-1:0] dataMem_data_o;
    logic [DATA_W-1:0] ALU_result_o;
    logic [ADDR_W-1:0] RDaddr_o;
    logic [DATA_W-1:0] wb_data_o;
    logic [1:0]        count_o;

    modport slave (
        input  flush_i, in_valid_i, RegWrite_i, MemtoReg_i, dataMem_data_i, ALU_result_i,
               RDaddr_i, out_ready_i,
        output in_ready_o, out_valid_o, RegWrite_o, MemtoReg_o, dataMem_data_o,
               ALU_result_o, RDaddr_o, wb_data_o, count_o
    );

    modport master (
        output flush_i, in_valid_i, RegWrite_i, MemtoReg_i, dataMem_data_i, ALU_result_i,
               RDaddr_i, out_ready_i,
        input  in_ready_o, out_valid_o, RegWrite_o, MemtoReg_o, dataMem_data_o,
               ALU_result_o, RDaddr_o, wb_data_o, count_o
    );
endinterface

// File: rtl/wb_pipe_skid.sv
// Two-entry (head + skid) writeback pipeline register with registered ready,
// synchronous flush and zero-register write suppression.
module wb_pipe_skid #(
    parameter int unsigned DATA_W        = 32,
    parameter int unsigned ADDR_W        = 5,
    parameter int unsigned ZERO_SUPPRESS = 1
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    wb_pipe_skid_if.slave bus
);

    typedef struct packed {
        logic              valid;
        logic              reg_write;
        logic              mem_to_reg;
        logic [DATA_W-1:0] mem_data;
        logic [DATA_W-1:0] alu_result;
        logic [ADDR_W-1:0] rd_addr;
    } beat_t;

    beat_t head_q, head_d;
    beat_t skid_q, skid_d;
    beat_t in_beat;
    logic  accept;
    logic  pop;
    logic  zero_dst;

    always_comb begin
        in_beat.valid      = 1'b1;
        in_beat.reg_write  = bus.RegWrite_i;
        in_beat.mem_to_reg = bus.MemtoReg_i;
        in_beat.mem_data   = bus.dataMem_data_i;
        in_beat.alu_result = bus.ALU_result_i;
        in_beat.rd_addr    = bus.RDaddr_i;
    end

    // Ready depends only on the skid register, so no path from out_ready_i.
    assign accept = bus.in_valid_i & ~skid_q.valid;
    assign pop    = head_q.valid & bus.out_ready_i;

    // Next-state: skid is only ever occupied while head is occupied.
    always_comb begin
        head_d = head_q;
        skid_d = skid_q;
        if (bus.flush_i) begin
            head_d.valid = 1'b0;
            skid_d.valid = 1'b0;
        end else if (skid_q.valid) begin
            if (pop) begin
                head_d       = skid_q;
                skid_d.valid = 1'b0;
            end
        end else if (head_q.valid) begin
            if (accept && pop) begin
                head_d = in_beat;
            end else if (accept) begin
                skid_d = in_beat;
            end else if (pop) begin
                head_d.valid = 1'b0;
            end
        end else if (accept) begin
            head_d = in_beat;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            head_q <= '0;
            skid_q <= '0;
        end else begin
            head_q <= head_d;
            skid_q <= skid_d;
        end
    end

    assign zero_dst = (ZERO_SUPPRESS != 0) && (head_q.rd_addr == '0);

    assign bus.in_ready_o     = ~skid_q.valid;
    assign bus.out_valid_o    = head_q.valid;
    assign bus.RegWrite_o     = head_q.reg_write & head_q.valid & ~zero_dst;
    assign bus.MemtoReg_o     = head_q.mem_to_reg & head_q.valid;
    assign bus.dataMem_data_o = head_q.mem_data;
    assign bus.ALU_result_o   = head_q.alu_result;
    assign bus.RDaddr_o       = head_q.rd_addr;
    assign bus.wb_data_o      = bus.MemtoReg_o ? head_q.mem_data : head_q.alu_result;
    assign bus.count_o        = {1'b0, head_q.valid} + {1'b0, skid_q.valid};

endmodule

// File: tb/tb_wb_pipe_skid.sv
// Scoreboard bench for wb_pipe_skid: directed streaming, backpressure, mux,
// flush and async-reset scenarios followed by a random stream.
module tb_wb_pipe_skid;
    localparam int unsigned DW = 32;
    localparam int unsigned AW = 5;

    typedef struct {
        logic [DW-1:0] wb;
        logic          rw;
        logic          m2r;
        logic [AW-1:0] rd;
        logic [DW-1:0] alu;
        logic [DW-1:0] mem;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    bit   last_acc;
    exp_t q[$];

    always #5 clk = ~clk;

    wb_pipe_skid_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    wb_pipe_skid #(.DATA_W(DW), .ADDR_W(AW), .ZERO_SUPPRESS(1)) dut (
        .clk_i  (clk),
        .rst_n_i(rst_n),
        .bus    (bus.slave)
    );

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic drive(input bit v, input bit rw, input bit m2r,
                         input logic [DW-1:0] mem, input logic [DW-1:0] alu,
                         input logic [AW-1:0] rd);
        bus.in_valid_i     = v;
        bus.RegWrite_i     = rw;
        bus.MemtoReg_i     = m2r;
        bus.dataMem_data_i = mem;
        bus.ALU_result_i   = alu;
        bus.RDaddr_i       = rd;
    endtask

    // One cycle: check status and head against the model, update model, advance.
    task automatic step();
        int   n;
        bit   acc;
        bit   pp;
        exp_t e;
        n   = q.size();
        acc = bus.in_valid_i && (n < 2);
        pp  = (n > 0) && bus.out_ready_i;
        check_eq("count", 32'(bus.count_o), 32'(n));
        check_eq("in_ready", 32'(bus.in_ready_o), 32'(n < 2));
        check_eq("out_valid", 32'(bus.out_valid_o), 32'(n > 0));
        if (pp) begin
            e = q.pop_front();
            check_eq("wb_data", bus.wb_data_o, e.wb);
            check_eq("regwrite", 32'(bus.RegWrite_o), 32'(e.rw));
            check_eq("memtoreg", 32'(bus.MemtoReg_o), 32'(e.m2r));
            check_eq("rdaddr", 32'(bus.RDaddr_o), 32'(e.rd));
            check_eq("alu", bus.ALU_result_o, e.alu);
            check_eq("mem", bus.dataMem_data_o, e.mem);
        end
        if (bus.flush_i) begin
            q.delete();
        end else if (acc) begin
            e.mem = bus.dataMem_data_i;
            e.alu = bus.ALU_result_i;
            e.rd  = bus.RDaddr_i;
            e.m2r = bus.MemtoReg_i;
            e.rw  = bus.RegWrite_i && (bus.RDaddr_i != '0);
            e.wb  = bus.MemtoReg_i ? bus.dataMem_data_i : bus.ALU_result_i;
            q.push_back(e);
        end
        last_acc = acc && !bus.flush_i;
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero_outputs(input string tag);
        check_eq({tag, "_out_valid"}, 32'(bus.out_valid_o), 32'd0);
        check_eq({tag, "_regwrite"}, 32'(bus.RegWrite_o), 32'd0);
        check_eq({tag, "_memtoreg"}, 32'(bus.MemtoReg_o), 32'd0);
        check_eq({tag, "_mem"}, bus.dataMem_data_o, 32'd0);
        check_eq({tag, "_alu"}, bus.ALU_result_o, 32'd0);
        check_eq({tag, "_rd"}, 32'(bus.RDaddr_o), 32'd0);
        check_eq({tag, "_wb"}, bus.wb_data_o, 32'd0);
        check_eq({tag, "_count"}, 32'(bus.count_o), 32'd0);
        check_eq({tag, "_in_ready"}, 32'(bus.in_ready_o), 32'd1);
    endtask

    initial begin
        bit done;
        rst_n           = 1'b0;
        bus.flush_i     = 1'b0;
        bus.out_ready_i = 1'b0;
        drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
        #1;
        check_zero_outputs("reset");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Streaming with downstream always ready.
        bus.out_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b1, 1'b0, 32'hFFFF_0000, 32'h10 + 32'(i), AW'(i + 1));
            step();
        end
        drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
        repeat (2) step();

        // Backpressure: A and B held, C stalls until release.
        bus.out_ready_i = 1'b0;
        drive(1'b1, 1'b1, 1'b0, 32'h1, 32'hAAAA_0000, 5'd1);
        step();
        drive(1'b1, 1'b1, 1'b0, 32'h2, 32'hBBBB_0000, 5'd2);
        step();
        drive(1'b1, 1'b1, 1'b0, 32'h3, 32'hCCCC_0000, 5'd3);
        repeat (2) step();
        check_eq("bp_count2", 32'(bus.count_o), 32'd2);
        check_eq("bp_ready0", 32'(bus.in_ready_o), 32'd0);
        bus.out_ready_i = 1'b1;
        done = 1'b0;
        for (int k = 0; k < 20 && !done; k++) begin
            step();
            done = last_acc;
        end
        check_eq("c_accepted", 32'(done), 32'd1);
        drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
        repeat (4) step();

        // Writeback mux and zero-destination suppression.
        drive(1'b1, 1'b1, 1'b1, 32'hDEAD_BEEF, 32'h1234_5678, 5'd0);
        step();
        drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
        check_eq("mux_wb", bus.wb_data_o, 32'hDEAD_BEEF);
        check_eq("suppress_rw", 32'(bus.RegWrite_o), 32'd0);
        step();
        drive(1'b1, 1'b1, 1'b1, 32'hDEAD_BEEF, 32'h1234_5678, 5'd7);
        step();
        drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
        check_eq("rd7_rw", 32'(bus.RegWrite_o), 32'd1);
        step();

        // Flush with full buffer, incoming beat and a same-cycle pop.
        bus.out_ready_i = 1'b0;
        drive(1'b1, 1'b1, 1'b0, 32'h11, 32'h21, 5'd4);
        step();
        drive(1'b1, 1'b1, 1'b0, 32'h12, 32'h22, 5'd5);
        step();
        drive(1'b1, 1'b1, 1'b0, 32'h13, 32'h23, 5'd6);
        bus.flush_i     = 1'b1;
        bus.out_ready_i = 1'b1;
        step();
        bus.flush_i = 1'b0;
        drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
        check_eq("flush_rw", 32'(bus.RegWrite_o), 32'd0);
        check_eq("flush_count", 32'(bus.count_o), 32'd0);
        repeat (2) step();

        // Asynchronous reset between edges with two beats held.
        bus.out_ready_i = 1'b0;
        drive(1'b1, 1'b1, 1'b1, 32'h5555_5555, 32'h6666_6666, 5'd9);
        step();
        drive(1'b1, 1'b1, 1'b1, 32'h7777_7777, 32'h8888_8888, 5'd10);
        step();
        drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
        check_eq("pre_rst_count", 32'(bus.count_o), 32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        check_zero_outputs("async_rst");
        q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready_i = 1'b1;
        drive(1'b1, 1'b1, 1'b0, 32'h0, 32'h4242_4242, 5'd3);
        step();
        drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
        check_eq("post_rst_wb", bus.wb_data_o, 32'h4242_4242);
        repeat (2) step();

        // Random traffic with occasional flush.
        for (int i = 0; i < 300; i++) begin
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  $urandom, $urandom, AW'($urandom_range(0, 31)));
            bus.out_ready_i = ($urandom_range(0, 2) != 0);
            bus.flush_i     = ($urandom_range(0, 29) == 0);
            step();
        end
        bus.flush_i = 1'b0;
        bus.out_ready_i = 1'b1;
        drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
        repeat (3) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/wb_pipe_skid.md
WB_PIPE_SKID -- requirements
Module: wb_pipe_skid

Interface
REQ-001 Parameter DATA_W, 32, width of memory-data and ALU-result paths.
REQ-002 Parameter ADDR_W, 5, width of destination register address.
REQ-003 Parameter ZERO_SUPPRESS, 1, when 1 RegWrite is forced low for destination address 0.
REQ-004 One clock; reset is asynchronous and active-low.
REQ-005 clk_i  input  1  sole clock, all state updates on rising edge.
REQ-006 rst_n_i  input  1  asynchronous active-low reset.
REQ-007 flush_i  input  1  synchronous flush, discards all held and incoming beats.
REQ-008 in_valid_i  input  1  upstream beat valid.
REQ-009 in_ready_o  output  1  stage can accept a beat this cycle.
REQ-010 RegWrite_i, MemtoReg_i  input  1 each  WB control of incoming beat.
REQ-011 dataMem_data_i, ALU_result_i  input  DATA_W each  incoming data.
REQ-012 RDaddr_i  input  ADDR_W  incoming destination register.
REQ-013 out_valid_o  output  1  head beat valid.
REQ-014 out_ready_i  input  1  downstream (writeback) consumes head this cycle.
REQ-015 RegWrite_o, MemtoReg_o  output  1 each  head beat control, gated per REQ-024.
REQ-016 dataMem_data_o, ALU_result_o  output  DATA_W each  head beat data.
REQ-017 RDaddr_o  output  ADDR_W  head beat destination.
REQ-018 wb_data_o  output  DATA_W  MemtoReg_o ? dataMem_data_o : ALU_result_o, combinational from registers.
REQ-019 count_o  output  2  number of held beats, 0..2.

Function
REQ-020 Storage: head register and skid register, each holding {valid, RegWrite, MemtoReg, mem data, ALU result, RDaddr}.
REQ-021 in_ready_o = NOT skid.valid, driven from a register (no combinational path from out_ready_i).
REQ-022 Accept = in_valid_i AND in_ready_o; pop = out_valid_o AND out_ready_i; out_valid_o = head.valid.
REQ-023 Latency: an accepted beat with head empty (or head popped same cycle, skid empty) appears on outputs next cycle.
REQ-024 RegWrite_o = head.RegWrite AND head.valid AND NOT (ZERO_SUPPRESS AND RDaddr_o == 0); MemtoReg_o = head.MemtoReg AND head.valid.
REQ-025 Transitions (count before -> after), no flush: 0: accept -> 1 (to head). 1: accept without pop -> 2 (to skid); accept with pop -> 1 (to head); pop without accept -> 0. 2: pop -> 1 (skid moves to head, skid cleared); no pop -> 2, inputs ignored.
REQ-026 Order preserved: beats leave in acceptance order; never overwrite a valid unpopped beat.
REQ-027 Data registers of an empty slot hold last values; only valid bits define content.
REQ-028 flush_i = 1: next edge clears head.valid and skid.valid, count_o = 0; beat accepted in same cycle discarded; pop in same cycle still counts as consumed.
REQ-029 Flush has priority over accept, pop and skid-to-head move.
REQ-030 count_o = head.valid + skid.valid.

Reset
REQ-031 rst_n_i low asynchronously forces: both valid bits 0, all control bits 0, all data and address registers 0.
REQ-032 During reset: out_valid_o = 0, RegWrite_o = 0, MemtoReg_o = 0, all data outputs 0, wb_data_o = 0, count_o = 0, in_ready_o = 1.
REQ-033 Reset asserted mid-transfer discards held beats; first edge after deassertion behaves as count 0.

Verification
REQ-034 Streaming: out_ready_i = 1, 4 back-to-back beats ALU_result 0x10..0x13, MemtoReg 0 -> each on wb_data_o exactly 1 cycle after acceptance, in_ready_o stays 1.
REQ-035 Backpressure: out_ready_i = 0, send beats A = 0xAAAA0000, B = 0xBBBB0000, C -> A,B held, count_o = 2, in_ready_o = 0, C not accepted; release -> A then B then C in order.
REQ-036 Mux/suppress: beat MemtoReg 1, mem data 0xDEADBEEF, RDaddr 0, RegWrite 1 -> wb_data_o = 0xDEADBEEF, RegWrite_o = 0; same with RDaddr 7 -> RegWrite_o = 1.
REQ-037 Flush: count_o = 2 plus in_valid_i = 1 with flush_i = 1 -> next cycle count_o = 0, out_valid_o = 0, RegWrite_o = 0, in_ready_o = 1.
REQ-038 Async reset: assert rst_n_i low between edges with count_o = 2 -> outputs zero immediately without a clock edge; after release, first beat passes with 1-cycle latency.
